uart_lite: RTL



---
 rtl/uart_lite_pkg.sv | 27 ++
 rtl/uart_lite_fifo.sv | 44 ++++
 rtl/uart_lite.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_lite_pkg.sv
// Shared constants and types for the uart_lite peripheral: register map, STATUS bit layout,
// FSM state types and the divisor floor.
package uart_lite_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int unsigned STAT_TX_FULL   = 0;
  localparam int unsigned STAT_TX_EMPTY  = 1;
  localparam int unsigned STAT_TX_BUSY   = 2;
  localparam int unsigned STAT_RX_VALID  = 3;
  localparam int unsigned STAT_RX_OVR    = 4;
  localparam int unsigned STAT_RX_FRAME  = 5;
  localparam int unsigned STAT_TX_DROP   = 6;

  localparam int unsigned DIV_MIN = 3;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'(DIV_MIN)) ? 16'(DIV_MIN) : v;
  endfunction

endpackage

// File: rtl/uart_lite_fifo.sv
// Synchronous FIFO for the TX path; pointers carry an extra wrap bit to tell full from empty.
// Pushes while full and pops while empty are ignored.
module uart_lite_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) &&
                   (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[Aw-1:0]];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_lite.sv
// Memory-mapped 8N1 UART: register decode, TX FIFO + TX FSM, synchronised RX FSM with a
// single-entry holding register, programmable divisor shared by both directions.
module uart_lite
  import uart_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TX_FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET     = 16'd433
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  write_i,
  input  logic                  sel_i,
  input  logic                  enable_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ready_o,
  output logic                  tx_o,
  input  logic                  rx_i
);

  // Bus decode
  logic            access, addr_hit, rd_any;
  logic            wr_tx, wr_div, rd_rx, rd_stat;
  logic [1:0]      reg_sel;
  logic [31:0]     rd_word, status_word;
  logic            ready_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [15:0]     div_q;
  logic            unused_bits;

  assign access   = sel_i & enable_i;
  assign addr_hit = (addr_i[ADDR_WIDTH-1:4] == '0);
  assign reg_sel  = addr_i[3:2];
  assign rd_any   = access & ~write_i;
  assign wr_tx    = access &  write_i & addr_hit & (reg_sel == REG_TXDATA);
  assign wr_div   = access &  write_i & addr_hit & (reg_sel == REG_DIV);
  assign rd_rx    = rd_any & addr_hit & (reg_sel == REG_RXDATA);
  assign rd_stat  = rd_any & addr_hit & (reg_sel == REG_STATUS);
  assign unused_bits = ^{addr_i[1:0], wdata_i[DATA_WIDTH-1:16]};

  // TX FIFO
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  uart_lite_fifo #(
    .Depth (TX_FIFO_DEPTH),
    .Width (8)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .push_i  (wr_tx),
    .wdata_i (wdata_i[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // TX FSM
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TxIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_rdata;
          tx_cnt_d   = div_q;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = div_q;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TxData: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = div_q;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == '0) begin
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_rdata;
            tx_cnt_d   = div_q;
            tx_state_d = TxStart;
          end else begin
            tx_state_d = TxIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    case (tx_state_q)
      TxStart: tx_o = 1'b0;
      TxData:  tx_o = tx_shift_q[0];
      default: tx_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // RX synchroniser; the third flop only serves falling-edge detection.
  logic rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_s3_q & ~rx_s2_q;

  // RX FSM
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_half;
  logic [16:0] div_inc;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_load;

  // Start-bit wait of (div+1)/2 cycles, counted down to zero.
  assign div_inc = {1'b0, div_q} + 17'd1;
  assign rx_half = div_inc[16:1] - 16'd1;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_load    = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_cnt_d   = rx_half;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_cnt_q == '0) begin
          if (!rx_s2_q) begin
            rx_cnt_d   = div_q;
            rx_bit_d   = '0;
            rx_state_d = RxData;
          end else begin
            rx_state_d = RxIdle;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RxData: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = div_q;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == '0) begin
          rx_load    = 1'b1;
          rx_state_d = RxIdle;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Holding register and sticky flags; a new event wins over a same-cycle STATUS clear.
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       ovr_q, ovr_d, frame_q, frame_d, drop_q, drop_d;

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_byte_d  = rx_byte_q;
    ovr_d      = ovr_q;
    frame_d    = frame_q;
    drop_d     = drop_q;
    if (rd_stat) begin
      ovr_d   = 1'b0;
      frame_d = 1'b0;
      drop_d  = 1'b0;
    end
    if (rd_rx) rx_valid_d = 1'b0;
    if (rx_load) begin
      rx_byte_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rd_rx) ovr_d = 1'b1;
      if (!rx_s2_q) frame_d = 1'b1;
    end
    if (wr_tx && fifo_full) drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      ovr_q      <= 1'b0;
      frame_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      ovr_q      <= ovr_d;
      frame_q    <= frame_d;
      drop_q     <= drop_d;
    end
  end

  // Read mux and bus response registers
  always_comb begin
    status_word                = '0;
    status_word[STAT_TX_FULL]  = fifo_full;
    status_word[STAT_TX_EMPTY] = fifo_empty;
    status_word[STAT_TX_BUSY]  = (tx_state_q != TxIdle);
    status_word[STAT_RX_VALID] = rx_valid_q;
    status_word[STAT_RX_OVR]   = ovr_q;
    status_word[STAT_RX_FRAME] = frame_q;
    status_word[STAT_TX_DROP]  = drop_q;
  end

  always_comb begin
    rd_word = '0;
    if (addr_hit) begin
      case (reg_sel)
        REG_RXDATA: rd_word = rx_valid_q ? {24'd0, rx_byte_q} : 32'h8000_0000;
        REG_STATUS: rd_word = status_word;
        REG_DIV:    rd_word = {16'd0, div_q};
        default:    rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      div_q   <= DIV_RESET;
    end else begin
      ready_q <= access;
      if (rd_any) rdata_q <= DATA_WIDTH'(rd_word);
      if (wr_div) div_q <= clamp_div(wdata_i[15:0]);
    end
  end

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;

endmodule
